// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory access unit: access sizes, FSM states,
// request kinds, strobe/store-data formatting and alignment rules.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  typedef enum logic [1:0] {FETCH, LOAD, STORE} kind_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  // Only the low two funct3 bits pick the size; undefined encodings fall to word.
  function automatic size_t size_of(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] strobe_of(input logic [1:0] f3_lo, input logic [1:0] off);
    case (size_of(f3_lo))
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_of(input logic [1:0] f3_lo, input logic [31:0] wdata);
    case (size_of(f3_lo))
      SZ_B:    return {4{wdata[7:0]}};
      SZ_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic misaligned_of(input logic fetch, input logic [1:0] f3_lo,
                                         input logic [1:0] off);
    if (fetch) return off != 2'b00;
    case (size_of(f3_lo))
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: picks the addressed byte/halfword lane of the
// read word and sign- or zero-extends it according to funct3.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        signed_ld;

  always_comb begin
    byte_lane = mem_rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    signed_ld = ~funct3[2];
    case (size_of(funct3[1:0]))
      SZ_B:    result = {{24{signed_ld & byte_lane[7]}}, byte_lane};
      SZ_H:    result = {{16{signed_ld & half_lane[15]}}, half_lane};
      default: result = mem_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Fetch/load/store bus engine: one request per transaction over a valid/ready
// memory handshake, holding the fetched instruction (IR) and load data (MDR).
module mem_access_unit #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] NOP_INSTR = mem_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_fetch,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              misaligned,
  output logic [31:0]       instr,
  output logic [31:0]       rdata,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);
  import mem_pkg::*;

  state_t      state_reg;
  kind_t       kind_reg;
  logic [1:0]  off_reg;
  logic [2:0]  f3_reg;
  logic [31:0] load_result;

  kind_t       req_kind;
  logic        any_req;
  logic        req_mis;

  // Request decode only feeds registers; nothing here reaches the bus directly.
  always_comb begin
    req_kind = LOAD;
    if (req_fetch)      req_kind = FETCH;
    else if (req_write) req_kind = STORE;
    any_req = req_fetch | req_write | req_read;
    req_mis = misaligned_of(req_fetch, funct3[1:0], addr[1:0]);
  end

  load_align u_load_align (
    .mem_rdata (mem_rdata),
    .addr_lo   (off_reg),
    .funct3    (f3_reg),
    .result    (load_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      kind_reg   <= FETCH;
      off_reg    <= 2'b00;
      f3_reg     <= 3'b000;
      busy       <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_wstrb  <= 4'b0000;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      instr      <= NOP_INSTR;
      rdata      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done       <= 1'b0;
          misaligned <= 1'b0;
          if (any_req) begin
            kind_reg <= req_kind;
            off_reg  <= addr[1:0];
            f3_reg   <= funct3;
            if (req_mis) begin
              state_reg  <= DONE;
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              state_reg <= BUS;
              busy      <= 1'b1;
              mem_valid <= 1'b1;
              mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
              mem_we    <= (req_kind == STORE);
              mem_wstrb <= (req_kind == STORE) ? strobe_of(funct3[1:0], addr[1:0]) : 4'b0000;
              mem_wdata <= wdata_of(funct3[1:0], wdata);
            end
          end
        end
        BUS: begin
          // Bus fields are held until the memory accepts; IR/MDR load on that edge.
          if (mem_ready) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            done      <= 1'b1;
            if (kind_reg == FETCH)     instr <= mem_rdata;
            else if (kind_reg == LOAD) rdata <= load_result;
          end
        end
        DONE: begin
          state_reg  <= IDLE;
          done       <= 1'b0;
          misaligned <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
